// File: rtl/pitch_stabilizer.sv
// Debounces the fft_pitch_detect peak-bin stream: commits a pitch after HOLD agreeing
// detections, converts it to Hz, and blanks the display after a silence timeout.
module pitch_stabilizer #(
    parameter int BIN_W          = 10,
    parameter int MIN_BIN        = 2,
    parameter int MAX_BIN        = 511,
    parameter int TOL            = 1,
    parameter int HOLD           = 4,
    parameter int TIMEOUT_CYCLES = 9216000,
    parameter int HZ_PER_BIN_Q8  = 12000,
    parameter int HZ_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] in_bin,
    input  logic             in_valid,
    output logic [BIN_W-1:0] out_bin,
    output logic [HZ_W-1:0]  out_hz,
    output logic             out_valid,
    output logic             locked
);

    localparam int STREAK_W = $clog2(HOLD + 1);
    localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PROD_W   = BIN_W + 24;

    localparam logic [BIN_W:0]    MIN_V      = (BIN_W+1)'(MIN_BIN);
    localparam logic [BIN_W:0]    MAX_V      = (BIN_W+1)'(MAX_BIN);
    localparam logic [BIN_W:0]    TOL_V      = (BIN_W+1)'(TOL);
    localparam logic [BIN_W:0]    DIFF_ONE   = (BIN_W+1)'(1);
    localparam logic [STREAK_W-1:0] HOLD_V   = STREAK_W'(HOLD);
    localparam logic [STREAK_W-1:0] STR_ONE  = STREAK_W'(1);
    localparam logic [IDLE_W-1:0] TIMEOUT_V  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] TIMEOUT_M1 = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [PROD_W-1:0] HZ_Q8_V    = PROD_W'(HZ_PER_BIN_Q8);
    localparam logic [PROD_W-1:0] HZ_MAX_V   = PROD_W'({HZ_W{1'b1}});

    logic [BIN_W-1:0]    cand;
    logic [STREAK_W-1:0] streak;
    logic [IDLE_W-1:0]   idle;

    logic                accepted;
    logic                agree;
    logic                commit;
    logic                timeout_hit;
    logic [BIN_W:0]      diff;
    logic [BIN_W:0]      abs_diff;
    logic [BIN_W-1:0]    cand_nxt;
    logic [STREAK_W-1:0] streak_nxt;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   hz_full;
    logic [HZ_W-1:0]     hz_nxt;

    always_comb begin
        accepted = in_valid && ({1'b0, in_bin} >= MIN_V) && ({1'b0, in_bin} <= MAX_V);

        // NOTE: one extra bit keeps the bin difference signed so |b - cand| is exact.
        diff     = {1'b0, in_bin} - {1'b0, cand};
        abs_diff = diff[BIN_W] ? (~diff + DIFF_ONE) : diff;
        agree    = (streak != '0) && (abs_diff <= TOL_V);

        cand_nxt   = agree ? cand : in_bin;
        streak_nxt = STR_ONE;
        if (agree) begin
            streak_nxt = (streak == HOLD_V) ? streak : streak + STR_ONE;
        end

        commit      = accepted && (streak_nxt == HOLD_V) && (streak < HOLD_V);
        timeout_hit = !accepted && (idle == TIMEOUT_M1);

        prod    = PROD_W'(cand_nxt) * HZ_Q8_V;
        hz_full = prod >> 8;
        hz_nxt  = (hz_full > HZ_MAX_V) ? {HZ_W{1'b1}} : hz_full[HZ_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand      <= '0;
            streak    <= '0;
            idle      <= '0;
            out_bin   <= '0;
            out_hz    <= '0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accepted) begin
                idle   <= '0;
                cand   <= cand_nxt;
                streak <= streak_nxt;
                if (commit) begin
                    out_bin   <= cand_nxt;
                    out_hz    <= hz_nxt;
                    locked    <= 1'b1;
                    out_valid <= 1'b1;
                end
            end else begin
                if (idle != TIMEOUT_V) begin
                    idle <= idle + IDLE_ONE;
                end
                // A rejected detection or a silence timeout breaks the current run.
                if (in_valid || timeout_hit) begin
                    streak <= '0;
                end
                if (timeout_hit && locked) begin
                    out_bin   <= '0;
                    out_hz    <= '0;
                    locked    <= 1'b0;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
